// File: rtl/rv_plic_gateway_cnt.sv
//-----------------------------------------------------------------------------
// rv_plic_gateway_cnt
//
// Per-source interrupt gateway sitting between raw peripheral interrupt lines
// and the PLIC priority/target logic. Every source is independently in level
// or rising-edge mode (selectable at run time). In edge mode a saturating
// counter remembers unclaimed edges so that a burst is delivered as repeated
// claim/complete rounds instead of being merged into one interrupt. A sticky
// overflow flag records edges dropped because the counter was full.
//
// Parameters
//   N_SOURCE  number of interrupt sources (>= 1)
//   CNT_W     edge-counter width per source (>= 1); counter saturates at
//             2**CNT_W-1
//
// Ports
//   clk_i     clock, all state on the rising edge
//   rst_ni    asynchronous active-low reset
//   src       raw interrupt lines
//   le        per source: 1 = rising-edge mode, 0 = level mode
//   en        per source capture enable; 0 ignores new events but keeps
//             pending state and already-counted edges
//   claim     one-cycle claim pulse from the PLIC target
//   complete  one-cycle completion pulse from the PLIC target
//   ovf_clr   clears ovf (wins over a same-cycle set)
//   ip        interrupt pending towards the PLIC core
//   ovf       sticky overflow: an edge was dropped at a saturated counter
//
// Configuration
//   RV_PLIC_GW_SYNC_EN  when defined, src passes through a 2-flop
//                       synchroniser before edge/level detection and the
//                       event-to-ip latency becomes 3 cycles. When undefined
//                       src must already be synchronous to clk_i and the
//                       latency is 1 cycle.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module rv_plic_gateway_cnt #(
   parameter int N_SOURCE = 32,
   parameter int CNT_W    = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [N_SOURCE-1:0] src,
   input  logic [N_SOURCE-1:0] le,
   input  logic [N_SOURCE-1:0] en,
   input  logic [N_SOURCE-1:0] claim,
   input  logic [N_SOURCE-1:0] complete,
   input  logic [N_SOURCE-1:0] ovf_clr,
   output logic [N_SOURCE-1:0] ip,
   output logic [N_SOURCE-1:0] ovf
);

   logic [N_SOURCE-1:0] s;        // sampled source lines
   logic [N_SOURCE-1:0] src_d_q;  // previous sample, for rising-edge detect
   logic [N_SOURCE-1:0] evt;      // qualified event this cycle

`ifdef RV_PLIC_GW_SYNC_EN
   logic [N_SOURCE-1:0] sync1_q;
   logic [N_SOURCE-1:0] sync2_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= src;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q;
`else
   assign s = src;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours, independent of block order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src_d_q <= '0;
      end else begin
         src_d_q <= s;
      end
   end

   assign evt = en & ((le & s & ~src_d_q) | (~le & s));

   for (genvar g = 0; g < N_SOURCE; g++) begin : g_src
      logic [CNT_W-1:0] cnt_q;   // edges seen but not yet claimed
      logic             ip_q;    // pending towards the PLIC
      logic             ia_q;    // in service: set with ip, held until completion
      logic             ovf_q;

      logic cnt_nz;
      logic cnt_full;
      logic take;
      logic req;
      logic inc;
      logic dec;
      logic ip_set;
      logic ovf_set;

      assign cnt_nz   = |cnt_q;
      assign cnt_full = &cnt_q;
      assign take     = claim[g] & ip_q;
      assign req      = le[g] ? (cnt_nz | evt[g]) : evt[g];

      // A claim on a full counter frees one slot, so a same-cycle edge still
      // fits and is counted rather than flagged as overflow.
      assign inc      = le[g] & evt[g] & (~cnt_full | take);
      // The non-zero guard only matters right after a level->edge switch
      // with an interrupt already pending; it keeps the counter from wrapping.
      assign dec      = le[g] & take & cnt_nz;
      assign ip_set   = ~ip_q & ~ia_q & req;
      assign ovf_set  = le[g] & evt[g] & cnt_full & ~take;

      // NOTE: the counters are plain flops, not a RAM, so they take the
      // asynchronous reset along with the rest of the per-source state.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            cnt_q <= '0;
            ip_q  <= 1'b0;
            ia_q  <= 1'b0;
            ovf_q <= 1'b0;
         end else begin
            if (!le[g]) begin
               cnt_q <= '0;
            end else if (inc && !dec) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end else if (dec && !inc) begin
               cnt_q <= cnt_q - CNT_W'(1);
            end

            // take and ip_set are mutually exclusive (take needs ip_q=1).
            if (take) begin
               ip_q <= 1'b0;
            end else if (ip_set) begin
               ip_q <= 1'b1;
            end

            // Completion is honoured only once the claim has dropped ip.
            if (ip_set) begin
               ia_q <= 1'b1;
            end else if (complete[g] && ia_q && !ip_q) begin
               ia_q <= 1'b0;
            end

            if (ovf_clr[g]) begin
               ovf_q <= 1'b0;
            end else if (ovf_set) begin
               ovf_q <= 1'b1;
            end
         end
      end

      assign ip[g]  = ip_q;
      assign ovf[g] = ovf_q;
   end

endmodule
